// File: rtl/dp_sequencer.sv
// Data-processing instruction sequencer: IDLE -> DECODE -> EXEC -> PCINC control word generator.
// Define DP_SEQ_COND_EN to enable ARM condition-code evaluation; otherwise every instruction is AL.
module dp_sequencer #(
  parameter int unsigned PC_REG = 15
) (
  input  logic        Clk,
  input  logic        RESET,
  input  logic        ir_valid,
  output logic        ir_ready,
  input  logic [31:0] IR,
  input  logic [3:0]  FLAGS_OUT,
  output logic [3:0]  FLAGS,
  output logic [31:0] IR_OUT,
  output logic [19:0] RSLCT,
  output logic [4:0]  OP,
  output logic        S,
  output logic        ALU_OUT,
  output logic        LOAD,
  output logic        LOADPC,
  output logic        IR_CU,
  output logic        ir_undef,
  output logic        done
);

  typedef enum logic [1:0] {StIdle, StDecode, StExec, StPcinc} state_e;

  localparam logic [3:0] PcIdx  = 4'(PC_REG);
  localparam logic [4:0] OpInc4 = 5'd17;

  state_e      state_q, state_d;
  logic [31:0] ir_q, ir_d;
  logic [3:0]  flags_q, flags_d;
  logic        ready_q, ready_d;
  logic [19:0] rslct_q, rslct_d;
  logic [4:0]  op_q, op_d;
  logic        s_q, s_d, alu_q, alu_d, load_q, load_d, loadpc_q, loadpc_d;
  logic        ircu_q, ircu_d, undef_q, undef_d, done_q, done_d;

  logic accept, cond_pass, is_dp, nxt_test, nxt_rd_pc;

  assign accept = ir_valid & ready_q;
  assign ir_d   = accept ? IR : ir_q;
  assign is_dp  = (ir_q[27:26] == 2'b00);

`ifdef DP_SEQ_COND_EN
  function automatic logic cond_eval(input logic [3:0] cond, input logic [3:0] f);
    logic n, z, c, v;
    {n, z, c, v} = f;
    case (cond)
      4'h0:    cond_eval = z;
      4'h1:    cond_eval = !z;
      4'h2:    cond_eval = c;
      4'h3:    cond_eval = !c;
      4'h4:    cond_eval = n;
      4'h5:    cond_eval = !n;
      4'h6:    cond_eval = v;
      4'h7:    cond_eval = !v;
      4'h8:    cond_eval = c & !z;
      4'h9:    cond_eval = !c | z;
      4'hA:    cond_eval = (n == v);
      4'hB:    cond_eval = (n != v);
      4'hC:    cond_eval = !z & (n == v);
      4'hD:    cond_eval = z | (n != v);
      4'hE:    cond_eval = 1'b1;
      default: cond_eval = 1'b0;
    endcase
  endfunction

  assign cond_pass = cond_eval(ir_q[31:28], flags_q);
`else
  assign cond_pass = 1'b1;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:   if (accept) state_d = StDecode;
      StDecode: state_d = (is_dp && cond_pass) ? StExec : StPcinc;
      StExec:   state_d = (ir_q[15:12] == PcIdx && ir_q[24:23] != 2'b10) ? StIdle : StPcinc;
      StPcinc:  state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // Flags commit at the end of EXEC using the S value driven during that cycle.
  assign flags_d = (state_q == StExec && s_q) ? FLAGS_OUT : flags_q;

  // Outputs are registered, so they are decoded from the state being entered.
  assign nxt_test  = (ir_d[24:23] == 2'b10);
  assign nxt_rd_pc = (ir_d[15:12] == PcIdx);

  always_comb begin
    ready_d  = (state_d == StIdle);
    rslct_d  = 20'h0;
    op_d     = 5'h0;
    s_d      = 1'b0;
    alu_d    = 1'b0;
    load_d   = 1'b0;
    loadpc_d = 1'b0;
    ircu_d   = 1'b0;
    undef_d  = 1'b0;
    done_d   = 1'b0;
    unique case (state_d)
      StIdle: ;
      StDecode: begin
        ircu_d  = 1'b1;
        rslct_d = {4'h0, ir_d[15:12], ir_d[11:8], ir_d[3:0], ir_d[19:16]};
        op_d    = {1'b0, ir_d[24:21]};
        undef_d = (ir_d[27:26] != 2'b00);
      end
      StExec: begin
        ircu_d   = 1'b1;
        rslct_d  = {4'h0, ir_d[15:12], ir_d[11:8], ir_d[3:0], ir_d[19:16]};
        op_d     = {1'b0, ir_d[24:21]};
        alu_d    = 1'b1;
        s_d      = ir_d[20] | nxt_test;
        load_d   = !nxt_test;
        loadpc_d = nxt_rd_pc & !nxt_test;
        done_d   = nxt_rd_pc & !nxt_test;
      end
      StPcinc: begin
        ircu_d   = 1'b1;
        rslct_d  = {4'h0, PcIdx, 4'h0, 4'h0, PcIdx};
        op_d     = OpInc4;
        alu_d    = 1'b1;
        loadpc_d = 1'b1;
        done_d   = 1'b1;
      end
    endcase
  end

  always_ff @(posedge Clk or negedge RESET) begin
    if (!RESET) begin
      state_q  <= StIdle;
      ir_q     <= 32'h0;
      flags_q  <= 4'h0;
      ready_q  <= 1'b0;
      rslct_q  <= 20'h0;
      op_q     <= 5'h0;
      s_q      <= 1'b0;
      alu_q    <= 1'b0;
      load_q   <= 1'b0;
      loadpc_q <= 1'b0;
      ircu_q   <= 1'b0;
      undef_q  <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ir_q     <= ir_d;
      flags_q  <= flags_d;
      ready_q  <= ready_d;
      rslct_q  <= rslct_d;
      op_q     <= op_d;
      s_q      <= s_d;
      alu_q    <= alu_d;
      load_q   <= load_d;
      loadpc_q <= loadpc_d;
      ircu_q   <= ircu_d;
      undef_q  <= undef_d;
      done_q   <= done_d;
    end
  end

  assign ir_ready = ready_q;
  assign FLAGS    = flags_q;
  assign IR_OUT   = ir_q;
  assign RSLCT    = rslct_q;
  assign OP       = op_q;
  assign S        = s_q;
  assign ALU_OUT  = alu_q;
  assign LOAD     = load_q;
  assign LOADPC   = loadpc_q;
  assign IR_CU    = ircu_q;
  assign ir_undef = undef_q;
  assign done     = done_q;

endmodule

// File: tb/tb_dp_sequencer.sv
// Scoreboard bench for dp_sequencer: expected control words are queued per instruction and
// a forked monitor compares them on every active (IR_CU) cycle.
module tb_dp_sequencer;

  logic        Clk = 1'b0;
  logic        RESET;
  logic        ir_valid;
  logic        ir_ready;
  logic [31:0] IR;
  logic [3:0]  FLAGS_OUT;
  logic [3:0]  FLAGS;
  logic [31:0] IR_OUT;
  logic [19:0] RSLCT;
  logic [4:0]  OP;
  logic        S, ALU_OUT, LOAD, LOADPC, IR_CU, ir_undef, done;

  int checks = 0;
  int errors = 0;
  logic [34:0] exp_q[$];

  localparam logic [19:0] PcW = 20'h0F00F;

  dp_sequencer #(.PC_REG(15)) dut (
    .Clk      (Clk),
    .RESET    (RESET),
    .ir_valid (ir_valid),
    .ir_ready (ir_ready),
    .IR       (IR),
    .FLAGS_OUT(FLAGS_OUT),
    .FLAGS    (FLAGS),
    .IR_OUT   (IR_OUT),
    .RSLCT    (RSLCT),
    .OP       (OP),
    .S        (S),
    .ALU_OUT  (ALU_OUT),
    .LOAD     (LOAD),
    .LOADPC   (LOADPC),
    .IR_CU    (IR_CU),
    .ir_undef (ir_undef),
    .done     (done)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic logic [34:0] ent(input logic [19:0] r, input logic [4:0] op, input logic s,
                                      input logic alu, input logic ld, input logic lpc,
                                      input logic und, input logic dn, input logic [3:0] fl);
    return {r, op, s, alu, ld, lpc, und, dn, fl};
  endfunction

  task automatic monitor();
    int n = 0;
    logic [34:0] got;
    forever begin
      @(negedge Clk);
      if (RESET && IR_CU) begin
        got = {RSLCT, OP, S, ALU_OUT, LOAD, LOADPC, ir_undef, done, FLAGS};
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL ctrl_%0d: got %h expected nothing (idle)", n, got);
        end else begin
          chk($sformatf("ctrl_%0d", n), 64'(got), 64'(exp_q.pop_front()));
        end
        n++;
      end
    end
  endtask

  // Issue one instruction, keep ir_valid high with junk while busy, measure latency to ready.
  task automatic run(input string name, input logic [31:0] ir, input logic [3:0] fo,
                     input int exp_lat);
    int n = 0;
    FLAGS_OUT = fo;
    while (!ir_ready && n < 20) begin
      @(posedge Clk); #1;
      n++;
    end
    chk({name, "_rdy"}, 64'(ir_ready), 64'd1);
    ir_valid = 1'b1;
    IR = ir;
    @(posedge Clk); #1;
    IR = 32'hE3A0F0FF;
    n = 0;
    while (!ir_ready && n < 10) begin
      @(posedge Clk); #1;
      n++;
    end
    ir_valid = 1'b0;
    chk({name, "_lat"}, 64'(n), 64'(exp_lat));
    chk({name, "_irout"}, 64'(IR_OUT), 64'(ir));
    chk({name, "_sbq"}, 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    RESET = 1'b0;
    ir_valid = 1'b0;
    IR = 32'h0;
    FLAGS_OUT = 4'h0;
    fork
      monitor();
    join_none
    #3;
    chk("rst_ir_out", 64'(IR_OUT), 64'd0);
    chk("rst_ctrl", 64'({RSLCT, OP, S, ALU_OUT, LOAD, LOADPC, IR_CU, ir_undef, done, FLAGS,
                         ir_ready}), 64'd0);
    @(negedge Clk);
    RESET = 1'b1;

    // ADD R1,R2,R3: flags must ignore FLAGS_OUT because S=0
    exp_q.push_back(ent(20'h01032, 5'd4, 0, 0, 0, 0, 0, 0, 4'h0));
    exp_q.push_back(ent(20'h01032, 5'd4, 0, 1, 1, 0, 0, 0, 4'h0));
    exp_q.push_back(ent(PcW, 5'd17, 0, 1, 0, 1, 0, 1, 4'h0));
    run("add", 32'hE0821003, 4'hF, 3);
    chk("add_flags", 64'(FLAGS), 64'h0);

    // SUBS R1,R2,R3
    exp_q.push_back(ent(20'h01032, 5'd2, 0, 0, 0, 0, 0, 0, 4'h0));
    exp_q.push_back(ent(20'h01032, 5'd2, 1, 1, 1, 0, 0, 0, 4'h0));
    exp_q.push_back(ent(PcW, 5'd17, 0, 1, 0, 1, 0, 1, 4'h6));
    run("subs", 32'hE0521003, 4'h6, 3);
    chk("subs_flags", 64'(FLAGS), 64'h6);
    chk("subs_carry", 64'(FLAGS[1]), 64'd1);

    // CMP R2,R3: S forced, no Rd write
    exp_q.push_back(ent(20'h00032, 5'd10, 0, 0, 0, 0, 0, 0, 4'h6));
    exp_q.push_back(ent(20'h00032, 5'd10, 1, 1, 0, 0, 0, 0, 4'h6));
    exp_q.push_back(ent(PcW, 5'd17, 0, 1, 0, 1, 0, 1, 4'h9));
    run("cmp", 32'hE1520003, 4'h9, 3);
    chk("cmp_flags", 64'(FLAGS), 64'h9);

    // ADDEQ with Z=0 (FLAGS = N,V set)
    exp_q.push_back(ent(20'h01032, 5'd4, 0, 0, 0, 0, 0, 0, 4'h9));
`ifdef DP_SEQ_COND_EN
    exp_q.push_back(ent(PcW, 5'd17, 0, 1, 0, 1, 0, 1, 4'h9));
    run("addeq", 32'h00821003, 4'hF, 2);
`else
    exp_q.push_back(ent(20'h01032, 5'd4, 0, 1, 1, 0, 0, 0, 4'h9));
    exp_q.push_back(ent(PcW, 5'd17, 0, 1, 0, 1, 0, 1, 4'h9));
    run("addeq", 32'h00821003, 4'hF, 3);
`endif

    // ADDMI with N=1 executes in both builds
    exp_q.push_back(ent(20'h01032, 5'd4, 0, 0, 0, 0, 0, 0, 4'h9));
    exp_q.push_back(ent(20'h01032, 5'd4, 0, 1, 1, 0, 0, 0, 4'h9));
    exp_q.push_back(ent(PcW, 5'd17, 0, 1, 0, 1, 0, 1, 4'h9));
    run("addmi", 32'h40821003, 4'h0, 3);

    // MOV PC,R0: done in EXEC, no PCINC
    exp_q.push_back(ent(20'h0F000, 5'd13, 0, 0, 0, 0, 0, 0, 4'h9));
    exp_q.push_back(ent(20'h0F000, 5'd13, 0, 1, 1, 1, 0, 1, 4'h9));
    run("movpc", 32'hE1A0F000, 4'h0, 2);

    // LDR: undefined for this sequencer
    exp_q.push_back(ent(20'h02001, 5'd12, 0, 0, 0, 0, 1, 0, 4'h9));
    exp_q.push_back(ent(PcW, 5'd17, 0, 1, 0, 1, 0, 1, 4'h9));
    run("ldr", 32'hE5912000, 4'h0, 2);

    // Reset during EXEC of an ADD
    exp_q.push_back(ent(20'h01032, 5'd4, 0, 0, 0, 0, 0, 0, 4'h9));
    ir_valid = 1'b1;
    IR = 32'hE0821003;
    @(posedge Clk); #1;
    ir_valid = 1'b0;
    @(posedge Clk); #1;
    RESET = 1'b0;
    #1;
    chk("mid_rst_ctrl", 64'({RSLCT, OP, S, ALU_OUT, LOAD, LOADPC, IR_CU, ir_undef, done, FLAGS,
                             ir_ready}), 64'd0);
    chk("mid_rst_ir_out", 64'(IR_OUT), 64'd0);
    @(posedge Clk); #1;
    chk("mid_rst_load", 64'({LOAD, LOADPC}), 64'd0);
    @(negedge Clk);
    RESET = 1'b1;
    @(posedge Clk); #1;
    chk("mid_rst_ready", 64'(ir_ready), 64'd1);
    chk("mid_rst_load2", 64'({LOAD, LOADPC, IR_CU}), 64'd0);
    chk("mid_rst_sbq", 64'(exp_q.size()), 64'd0);

    // Recovery after reset
    exp_q.push_back(ent(20'h01032, 5'd4, 0, 0, 0, 0, 0, 0, 4'h0));
    exp_q.push_back(ent(20'h01032, 5'd4, 0, 1, 1, 0, 0, 0, 4'h0));
    exp_q.push_back(ent(PcW, 5'd17, 0, 1, 0, 1, 0, 1, 4'h0));
    run("add2", 32'hE0821003, 4'h0, 3);

    repeat (2) @(posedge Clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
